mips_mem_arbiter: RTL and testbench

- Shares the single data-memory port between the mips_cpu data interface and a second requester (DMA/debug loader) using a valid/ready handshake.
- Sits between mips_cpu and the data memory; drives the CPU's en input to stall the pipeline when the requester must be served.
- Returns 1-cycle-latency read data to both sides, including read data held for a stalled CPU.
- Free CPU slots are given to DMA at once; a starvation counter forces a one-cycle CPU stall.

---
 rtl/mips_mem_arb_pkg.sv | 16 +
 rtl/mips_mem_arb_if.sv | 51 +++++
 rtl/mips_rd_hold.sv | 48 ++++
 rtl/mips_mem_arbiter.sv | 98 +++++++++
 tb/tb_mips_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types and widths for the CPU/DMA data-memory arbiter.
package mips_mem_arb_pkg;

    // Width of the DMA starvation counter.
    localparam int CNT_W = 8;
    // Byte-enable width of the 32-bit data path.
    localparam int BE_W  = 4;

    // Who owns the memory port in the current cycle.
    typedef enum logic [1:0] {
        GNT_CPU,    // CPU owns the port (idle or accessing)
        GNT_STEAL,  // DMA takes a slot the CPU is not using
        GNT_FORCE   // DMA has waited too long; the CPU is stalled for one cycle
    } gnt_e;

endpackage

// File: rtl/mips_mem_arb_if.sv
// Bus bundle for the arbiter: CPU data port, DMA request/response port and
// the shared data-memory port. The slave modport is the arbiter's view; the
// master modport is the surrounding environment (CPU, DMA engine, memory).
interface mips_mem_arb_if
    import mips_mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    // CPU side
    logic [BE_W-1:0] cpu_mem_write_en;
    logic            cpu_mem_read_en;
    logic [AW-1:0]   cpu_mem_addr;
    logic [DW-1:0]   cpu_mem_write_data;
    logic [DW-1:0]   cpu_mem_read_data;

    // DMA side
    logic            dma_req_valid;
    logic            dma_req_ready;
    logic [BE_W-1:0] dma_req_we;
    logic [AW-1:0]   dma_req_addr;
    logic [DW-1:0]   dma_req_wdata;
    logic            dma_rsp_valid;
    logic [DW-1:0]   dma_rsp_rdata;

    // Memory side
    logic [BE_W-1:0] mem_write_en;
    logic            mem_read_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data;

    modport slave (
        input  cpu_mem_write_en, cpu_mem_read_en, cpu_mem_addr, cpu_mem_write_data,
        output cpu_mem_read_data,
        input  dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
        output dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
        output mem_write_en, mem_read_en, mem_addr, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output cpu_mem_write_en, cpu_mem_read_en, cpu_mem_addr, cpu_mem_write_data,
        input  cpu_mem_read_data,
        output dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
        input  mem_write_en, mem_read_en, mem_addr, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/mips_rd_hold.sv
// CPU read-data return path. Memory data arrives one cycle after the read is
// issued; if the CPU is stalled in that cycle the data is parked here and
// replayed until the CPU advances again.
module mips_rd_hold #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_en_i,        // CPU advancing this cycle
    input  logic          rd_issue_i,      // CPU read issued to memory this cycle
    input  logic [DW-1:0] mem_read_data_i,
    output logic [DW-1:0] cpu_read_data_o
);

    logic          pend_q,      pend_d;
    logic          hold_vld_q,  hold_vld_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    // Next state: remember an issued read, capture its data if the CPU is stalled.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pend_d      = rd_issue_i;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        if (pend_q && !cpu_en_i) begin
            hold_vld_d  = 1'b1;
            hold_data_d = mem_read_data_i;
        end else if (cpu_en_i) begin
            hold_vld_d  = 1'b0;
        end
        cpu_read_data_o = hold_vld_q ? hold_data_q : mem_read_data_i;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            pend_q      <= pend_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the single data-memory port between the CPU data interface and a
// DMA/debug requester. The DMA takes idle CPU slots immediately; if the CPU
// keeps the port busy for STARVE_LIMIT cycles the CPU is stalled for one
// cycle so the DMA can get through.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8      // 1..255
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic         cpu_en_o,
    mips_mem_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    gnt_e             gnt;
    logic             cpu_acc;
    logic             dma_gnt;
    logic             dma_rd;
    logic             cpu_rd_issue;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rsp_vld_q, rsp_vld_d;

    // Grant decision and CPU enable; everything is held off while in reset.
    always_comb begin
        gnt     = GNT_CPU;
        cpu_acc = en_i & (bus.cpu_mem_read_en | (|bus.cpu_mem_write_en));
        if (rst_ni && bus.dma_req_valid) begin
            if (!cpu_acc) begin
                gnt = GNT_STEAL;
            end else if (wait_q == LIMIT) begin
                gnt = GNT_FORCE;
            end
        end
        dma_gnt       = (gnt != GNT_CPU);
        dma_rd        = (bus.dma_req_we == '0);
        cpu_en_o      = rst_ni & en_i & (gnt != GNT_FORCE);
        cpu_rd_issue  = cpu_en_o & ~dma_gnt & bus.cpu_mem_read_en;
        bus.dma_req_ready = dma_gnt;
    end

    // Memory port mux: DMA when granted, CPU when it owns the port and accesses.
    always_comb begin
        bus.mem_write_en   = '0;
        bus.mem_read_en    = 1'b0;
        bus.mem_addr       = bus.cpu_mem_addr;
        bus.mem_write_data = bus.cpu_mem_write_data;
        if (dma_gnt) begin
            bus.mem_write_en   = bus.dma_req_we;
            bus.mem_read_en    = dma_rd;
            bus.mem_addr       = bus.dma_req_addr;
            bus.mem_write_data = bus.dma_req_wdata;
        end else if (cpu_en_o && cpu_acc) begin
            bus.mem_write_en   = bus.cpu_mem_write_en;
            bus.mem_read_en    = bus.cpu_mem_read_en;
        end
    end

    // Starvation counter and DMA response next state.
    always_comb begin
        wait_d = wait_q;
        if (!bus.dma_req_valid || dma_gnt) begin
            wait_d = '0;
        end else if (wait_q < LIMIT) begin
            wait_d = wait_q + 1'b1;
        end
        rsp_vld_d = dma_gnt & dma_rd;
    end

    // State registers; reset drops any in-flight DMA response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q    <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign bus.dma_rsp_valid = rsp_vld_q;
    assign bus.dma_rsp_rdata = bus.mem_read_data;

    mips_rd_hold #(.DW(DW)) u_rd_hold (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cpu_en_i        (cpu_en_o),
        .rd_issue_i      (cpu_rd_issue),
        .mem_read_data_i (bus.mem_read_data),
        .cpu_read_data_o (bus.cpu_mem_read_data)
    );

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural 1-cycle data memory.
// DMA read responses and memory writes are checked by a scoreboard monitor.
module tb_mips_mem_arbiter;

    logic clk;
    logic rst_ni;
    logic en;
    logic cpu_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] dma_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem[bit [31:0]];

    mips_mem_arb_if #(.AW(32), .DW(32)) bus ();

    mips_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .en_i     (en),
        .cpu_en_o (cpu_en),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: byte writes, registered read data.
    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.mem_write_en != 4'h0) begin
            w = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_en[b]) w[8*b +: 8] = bus.mem_write_data[8*b +: 8];
            mem[bus.mem_addr] = w;
        end
        if (bus.mem_read_en)
            bus.mem_read_data <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.dma_rsp_valid === 1'b1) begin
                if (dma_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dma_rsp: got unexpected %h, required none (t=%0t)",
                             bus.dma_rsp_rdata, $time);
                end else begin
                    check("dma_rsp", 80'(bus.dma_rsp_rdata), 80'(dma_q.pop_front()));
                end
            end
            if (bus.mem_write_en !== 4'h0) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_wr: got unexpected be=%h addr=%h data=%h, required none (t=%0t)",
                             bus.mem_write_en, bus.mem_addr, bus.mem_write_data, $time);
                end else begin
                    check("mem_wr", 80'({bus.mem_write_en, bus.mem_addr, bus.mem_write_data}),
                          80'(wr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic re, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.cpu_mem_read_en    = re;
        bus.cpu_mem_write_en   = we;
        bus.cpu_mem_addr       = addr;
        bus.cpu_mem_write_data = wd;
    endtask

    task automatic set_dma(input logic v, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.dma_req_valid = v;
        bus.dma_req_we    = we;
        bus.dma_req_addr  = addr;
        bus.dma_req_wdata = wd;
    endtask

    // DMA write issued while the CPU is idle (stolen slot).
    task automatic dma_write(input logic [31:0] addr, input logic [31:0] data);
        cyc();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b1, 4'hF, addr, data);
        wr_q.push_back({4'hF, addr, data});
        #1;
        check("steal_wr_ready", 80'(bus.dma_req_ready), 80'(1));
        check("steal_wr_cpu_en", 80'(cpu_en), 80'(1));
    endtask

    initial begin
        rst_ni = 1'b0;
        en     = 1'b1;
        set_cpu(1'b1, 4'h0, 32'h0, 32'h0);
        set_dma(1'b1, 4'h0, 32'h100, 32'h0);
        #2;
        // Outputs are forced idle while reset is held.
        check("rst_cpu_en", 80'(cpu_en), 80'(0));
        check("rst_ready", 80'(bus.dma_req_ready), 80'(0));
        check("rst_mem_we", 80'(bus.mem_write_en), 80'(0));
        check("rst_mem_re", 80'(bus.mem_read_en), 80'(0));
        check("rst_rsp_valid", 80'(bus.dma_rsp_valid), 80'(0));
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        rst_ni = 1'b1;

        // Test 1: DMA write then read with the CPU idle.
        dma_write(32'h100, 32'hDEADBEEF);
        check("t1_mem_addr", 80'(bus.mem_addr), 80'(32'h100));
        cyc();
        set_dma(1'b1, 4'h0, 32'h100, 32'h0);
        dma_q.push_back(32'hDEADBEEF);
        #1;
        check("t1_rd_ready", 80'(bus.dma_req_ready), 80'(1));
        check("t1_mem_re", 80'(bus.mem_read_en), 80'(1));
        cyc();
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();

        // Test 2: CPU busy every cycle, forced grant on cycles 8 and 17.
        for (int i = 0; i < 18; i++) begin
            cyc();
            set_cpu(1'b1, 4'h0, 32'h400, 32'h0);
            set_dma(1'b1, 4'h0, 32'h100, 32'h0);
            if (i == 8 || i == 17) dma_q.push_back(32'hDEADBEEF);
            #1;
            check("t2_force_ready", 80'(bus.dma_req_ready), 80'((i == 8 || i == 17) ? 1 : 0));
            check("t2_force_cpu_en", 80'(cpu_en), 80'((i == 8 || i == 17) ? 0 : 1));
        end
        cyc();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);

        // Test 3/4: CPU read held across a forced stall; stalled store issued once.
        dma_write(32'h200, 32'h12345678);
        dma_write(32'h204, 32'h55AA55AA);
        cyc();
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i < 7)       set_cpu(1'b1, 4'h0, 32'h400, 32'h0);
            else if (i == 7) set_cpu(1'b1, 4'h0, 32'h200, 32'h0);
            else             set_cpu(1'b0, 4'hF, 32'h300, 32'hCAFEF00D);
            if (i < 9) set_dma(1'b1, 4'h0, 32'h204, 32'h0);
            else       set_dma(1'b0, 4'h0, 32'h0, 32'h0);
            if (i == 8) dma_q.push_back(32'h55AA55AA);
            if (i == 9) wr_q.push_back({4'hF, 32'h300, 32'hCAFEF00D});
            #1;
            if (i == 8) begin
                check("t3_force_cpu_en", 80'(cpu_en), 80'(0));
                check("t3_force_addr", 80'(bus.mem_addr), 80'(32'h204));
                check("t3_cpu_rd_t1", 80'(bus.cpu_mem_read_data), 80'(32'h12345678));
            end
            if (i == 9) begin
                check("t3_resume_cpu_en", 80'(cpu_en), 80'(1));
                check("t4_sw_addr", 80'(bus.mem_addr), 80'(32'h300));
                check("t3_cpu_rd_t2", 80'(bus.cpu_mem_read_data), 80'(32'h12345678));
            end
        end
        cyc();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b1, 4'h0, 32'h300, 32'h0);
        dma_q.push_back(32'hCAFEF00D);
        cyc();
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);

        // Test 5: en low, four back-to-back DMA reads while the CPU is held.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, d;
            case (i)
                0: begin a = 32'h100; d = 32'hDEADBEEF; end
                1: begin a = 32'h200; d = 32'h12345678; end
                2: begin a = 32'h204; d = 32'h55AA55AA; end
                default: begin a = 32'h300; d = 32'hCAFEF00D; end
            endcase
            cyc();
            set_cpu(1'b1, 4'h0, 32'h400, 32'h0);
            set_dma(1'b1, 4'h0, a, 32'h0);
            dma_q.push_back(d);
            #1;
            check("t5_ready", 80'(bus.dma_req_ready), 80'(1));
            check("t5_cpu_en", 80'(cpu_en), 80'(0));
            check("t5_wait_cnt", 80'(dut.wait_q), 80'(0));
        end
        cyc();
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        en = 1'b1;

        // Test 6: reset asserted while a DMA read response is in flight.
        cyc();
        set_dma(1'b1, 4'h0, 32'h100, 32'h0);
        cyc();
        rst_ni = 1'b0;
        set_cpu(1'b1, 4'h0, 32'h400, 32'h0);
        #1;
        check("t6_rst_rsp_valid", 80'(bus.dma_rsp_valid), 80'(0));
        check("t6_rst_cpu_en", 80'(cpu_en), 80'(0));
        check("t6_rst_ready", 80'(bus.dma_req_ready), 80'(0));
        check("t6_rst_mem_re", 80'(bus.mem_read_en), 80'(0));
        check("t6_rst_mem_we", 80'(bus.mem_write_en), 80'(0));
        set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_post_rsp_valid", 80'(bus.dma_rsp_valid), 80'(0));
        end

        cyc();
        cyc();
        check("dma_q_drained", 80'(dma_q.size()), 80'(0));
        check("wr_q_drained", 80'(wr_q.size()), 80'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
